multi_pulse_sync_rx: RTL and testbench
======================================

MULTI_PULSE_SYNC_RX -- requirements
Module: multi_pulse_sync_rx

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent pulse channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth per channel (2..4).
REQ-003 SHALL have parameter CNT_W, default 2, width of the per-channel pending-pulse counter (1..8).
REQ-004 SHALL have port clk_out  input  1  the single receive-domain clock; all flops are on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port toggle_in  input  NUM_CH  per-channel source toggle, asynchronous to clk_out; each change means one source pulse.
REQ-007 SHALL have port pulse_valid  output  1  a pulse is offered.
REQ-008 SHALL have port pulse_ch  output  $clog2(NUM_CH) (min 1)  channel index of the offered pulse.
REQ-009 SHALL have port pulse_ready  input  1  consumer accepts the offered pulse.
REQ-010 SHALL have port ovf_flag  output  NUM_CH  sticky per-channel overflow (REQ-030).
REQ-011 SHALL have port ovf_clr  input  NUM_CH  per-channel overflow clear (REQ-030).

Function
REQ-012 SHALL pass each toggle_in bit through SYNC_STAGES flops, then one history flop; edge[i] = last stage XOR history.
REQ-013 SHALL hold a warm-up counter after reset and force edge to 0 for the first SYNC_STAGES+1 clk_out edges after resetn deasserts; history keeps tracking during warm-up.
REQ-014 SHALL increment pending[i] on the edge following edge[i]=1.
REQ-015 SHALL decrement pending[i] on a handshake (pulse_valid & pulse_ready & pulse_ch==i).
REQ-016 SHALL leave pending[i] unchanged when increment and decrement coincide.
REQ-017 SHALL saturate pending[i] at 2^CNT_W-1; an increment at saturation is dropped.
REQ-018 SHALL implement a two-state FSM IDLE/OFFER; reset state IDLE.
REQ-019 In IDLE with any pending nonzero, SHALL latch the round-robin winner into pulse_ch and go to OFFER; otherwise stay in IDLE.
REQ-020 Round-robin SHALL search upward from pointer rr_ptr with wrap-around; rr_ptr resets to 0 and becomes winner+1 (mod NUM_CH) on handshake.
REQ-021 In OFFER, pulse_valid SHALL be 1 and pulse_ch SHALL be held stable until handshake; on handshake return to IDLE.
REQ-022 pulse_valid SHALL be 0 in IDLE; maximum throughput is one pulse per two cycles.
REQ-023 Latency SHALL be exactly SYNC_STAGES+2 clk_out edges from the first edge sampling a toggle change to pulse_valid high, when idle, pending zero, and the channel wins arbitration.
REQ-024 Each toggle_in change SHALL produce exactly one pulse unless dropped per REQ-017.
REQ-025 Source toggles on a channel SHALL be at least 2 clk_out periods apart; closer spacing is outside contract.

Reset
REQ-026 resetn low SHALL clear, asynchronously, all synchroniser, history, pending, warm-up, rr_ptr, FSM and ovf_flag state to 0 / IDLE.
REQ-027 Reset values SHALL be pulse_valid=0, pulse_ch=0, ovf_flag=0.
REQ-028 Reset asserted in OFFER SHALL drop pulse_valid immediately and discard all pending pulses.
REQ-029 Toggle inputs held at 1 through reset release SHALL generate no pulse (REQ-013).

Configuration
REQ-030 With macro PULSE_SYNC_OVF_EN defined: ovf_flag[i] sets on a dropped increment, clears on ovf_clr[i], and set wins if both occur in the same cycle.
REQ-031 Without PULSE_SYNC_OVF_EN: ovf_flag is tied to 0, ovf_clr is ignored, and no overflow flops exist.

Structure
REQ-032 Package pulse_sync_pkg SHALL hold the FSM state enum (IDLE, OFFER) and the SYNC_STAGES min/max limit constants.
REQ-033 The per-channel synchroniser plus history flop SHALL be sub-module sync_chain, with parameter SYNC_STAGES, instantiated NUM_CH times.

Verification (NUM_CH=4, SYNC_STAGES=2, CNT_W=2, macro defined)
REQ-034 Toggle ch2 once after warm-up, pulse_ready=1 -> single pulse_valid with pulse_ch=2, rising 4 edges after sampling.
REQ-035 Toggle ch0, ch1, ch3 in the same cycle, ready=1, rr_ptr=0 -> pulses ch0, ch1, ch3, each spaced 2 cycles.
REQ-036 ready=0 and ch1 toggled 5 times 4 cycles apart -> pending[1]=3 and ovf_flag[1]=1; then ready=1 -> exactly 3 ch1 pulses; ovf_clr[1] -> flag 0.
REQ-037 toggle_in=4'b1111 held across reset release -> no pulse_valid for 50 cycles.
REQ-038 ch0 toggled every 3 cycles plus ch3 once -> ch3 granted within 2 handshakes.
REQ-039 resetn asserted during OFFER -> pulse_valid 0 without a clock; after release, no stale pulses are emitted.

Source files
------------

// File: rtl/pulse_sync_pkg.sv
// Shared types and limits for the multi-channel pulse synchroniser receiver.
package pulse_sync_pkg;

  // Output handshake FSM states.
  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  // Allowed synchroniser depth per channel.
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/sync_chain.sv
// One channel of toggle synchronisation: SYNC_STAGES flops into the clk_out
// domain, then a history flop. edge_o is high for one cycle per toggle change.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_out,
  input  logic resetn,
  input  logic toggle_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift the asynchronous toggle through the synchroniser, then into history.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk_out or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/multi_pulse_sync_rx.sv
// Multi-channel toggle-to-pulse receiver. Each channel's toggle is
// synchronised, converted to an edge, and accumulated in a saturating pending
// counter. A round-robin arbiter offers one pending pulse at a time on a
// valid/ready handshake.
// Optional feature: define PULSE_SYNC_OVF_EN to get sticky per-channel
// overflow flags (set on a dropped increment, cleared by ovf_clr, set wins).
module multi_pulse_sync_rx
  import pulse_sync_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int SYNC_STAGES = 2,
  parameter  int CNT_W       = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_out,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] toggle_in,
  output logic              pulse_valid,
  output logic [CH_W-1:0]   pulse_ch,
  input  logic              pulse_ready,
  output logic [NUM_CH-1:0] ovf_flag,
  input  logic [NUM_CH-1:0] ovf_clr
);

  localparam int               WARM_N  = SYNC_STAGES + 1;
  localparam int               WARM_W  = $clog2(WARM_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync_stages
    $error("multi_pulse_sync_rx: SYNC_STAGES out of range");
  end

  logic [WARM_W-1:0] warm_q;
  logic              warm_done;
  logic [NUM_CH-1:0] raw_edge;
  logic [NUM_CH-1:0] edge_v;
  logic [NUM_CH-1:0] dec;
  logic [NUM_CH-1:0] drop;
  logic [CNT_W-1:0]  pend_q [NUM_CH];
  logic [CNT_W-1:0]  pend_d [NUM_CH];
  logic              handshake;
  logic              found;
  logic [CH_W-1:0]   winner;
  state_e            state_q;
  logic              valid_q;
  logic [CH_W-1:0]   pulse_ch_q;
  logic [CH_W-1:0]   rr_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_out  (clk_out),
      .resetn   (resetn),
      .toggle_i (toggle_in[g]),
      .edge_o   (raw_edge[g])
    );
  end

  // Count the first SYNC_STAGES+1 edges after reset; edges are masked until done
  // so that levels already present at reset release never look like toggles.
  always_ff @(posedge clk_out or negedge resetn) begin
    if (!resetn) begin
      warm_q <= '0;
    end else if (!warm_done) begin
      warm_q <= warm_q + WARM_W'(1);
    end
  end

  assign warm_done = (warm_q == WARM_W'(WARM_N));
  assign edge_v    = raw_edge & {NUM_CH{warm_done}};
  assign handshake = valid_q & pulse_ready;

  // Next pending count per channel: +1 on edge, -1 on handshake, hold on both,
  // and drop the increment when already saturated.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      dec[i]    = handshake && (pulse_ch_q == CH_W'(i));
      drop[i]   = edge_v[i] && !dec[i] && (pend_q[i] == CNT_MAX);
      pend_d[i] = pend_q[i];
      if (edge_v[i] && !dec[i] && (pend_q[i] != CNT_MAX)) begin
        pend_d[i] = pend_q[i] + CNT_W'(1);
      end else if (!edge_v[i] && dec[i]) begin
        pend_d[i] = pend_q[i] - CNT_W'(1);
      end
    end
  end

  // Pending counters.
  // NOTE: this small array is true state and must start empty, so unlike a
  // data RAM it is cleared by reset.
  always_ff @(posedge clk_out or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) pend_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) pend_q[i] <= pend_d[i];
    end
  end

  // Round-robin search upward from rr_q, wrapping, for the first nonzero count.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      int idx;
      idx = int'(rr_q) + off;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && (pend_q[idx] != '0)) begin
        found  = 1'b1;
        winner = CH_W'(idx);
      end
    end
  end

  // Offer FSM: latch the winner in IDLE, hold it in OFFER until accepted.
  always_ff @(posedge clk_out or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      pulse_ch_q <= '0;
      rr_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            pulse_ch_q <= winner;
            valid_q    <= 1'b1;
            state_q    <= OFFER;
          end
        end
        OFFER: begin
          if (pulse_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
            rr_q    <= (int'(pulse_ch_q) == NUM_CH - 1) ? '0 : pulse_ch_q + CH_W'(1);
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pulse_valid = valid_q;
  assign pulse_ch    = pulse_ch_q;

`ifdef PULSE_SYNC_OVF_EN
  logic [NUM_CH-1:0] ovf_q;

  // Sticky overflow flags; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_out or negedge resetn) begin
    if (!resetn) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q & ~ovf_clr) | drop;
    end
  end

  assign ovf_flag = ovf_q;
`else
  logic unused_ovf;

  assign ovf_flag   = '0;
  assign unused_ovf = ^{ovf_clr, drop};
`endif

endmodule

// File: tb/tb_multi_pulse_sync_rx.sv
// Directed bench for multi_pulse_sync_rx (NUM_CH=4, SYNC_STAGES=2, CNT_W=2).
// Overflow expectations follow whether PULSE_SYNC_OVF_EN is defined.
module tb_multi_pulse_sync_rx;

  localparam int NUM_CH      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 2;
  localparam int CH_W        = 2;
`ifdef PULSE_SYNC_OVF_EN
  localparam logic [3:0] OVF1_EXP = 4'b0010;
`else
  localparam logic [3:0] OVF1_EXP = 4'b0000;
`endif

  logic              clk_out     = 1'b0;
  logic              resetn      = 1'b0;
  logic [NUM_CH-1:0] toggle_in   = '0;
  logic              pulse_ready = 1'b0;
  logic [NUM_CH-1:0] ovf_clr     = '0;
  logic              pulse_valid;
  logic [CH_W-1:0]   pulse_ch;
  logic [NUM_CH-1:0] ovf_flag;

  int n_cmp = 0;
  int n_err = 0;

  multi_pulse_sync_rx #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_out     (clk_out),
    .resetn      (resetn),
    .toggle_in   (toggle_in),
    .pulse_valid (pulse_valid),
    .pulse_ch    (pulse_ch),
    .pulse_ready (pulse_ready),
    .ovf_flag    (ovf_flag),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk_out = ~clk_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and land on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_out);
    @(negedge clk_out);
  endtask

  // Reset with the given toggle level applied while reset is low, then warm up.
  task automatic do_reset(input logic [NUM_CH-1:0] tog);
    resetn      = 1'b0;
    pulse_ready = 1'b0;
    ovf_clr     = '0;
    toggle_in   = tog;
    tick(2);
    check("rst_valid", pulse_valid, 1'b0);
    check("rst_ch", pulse_ch, 2'd0);
    check("rst_ovf", ovf_flag, 4'b0000);
    resetn = 1'b1;
    tick(SYNC_STAGES + 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int hs;
    int hs_at;
    logic got3;
    logic found;
    logic [CH_W-1:0] b_ch [3];
    b_ch = '{2'd0, 2'd1, 2'd3};

    tick(1);

    // A: single toggle on ch2, latency and no duplicate.
    do_reset(toggle_in);
    pulse_ready = 1'b1;
    toggle_in[2] = ~toggle_in[2];
    tick(1); check("a_lat_e1", pulse_valid, 1'b0);
    tick(1); check("a_lat_e2", pulse_valid, 1'b0);
    tick(1); check("a_lat_e3", pulse_valid, 1'b0);
    tick(1); check("a_lat_e4_valid", pulse_valid, 1'b1);
    check("a_lat_e4_ch", pulse_ch, 2'd2);
    tick(1); check("a_after_hs", pulse_valid, 1'b0);
    cnt = 0;
    repeat (10) begin tick(1); if (pulse_valid) cnt++; end
    check("a_extra_pulses", cnt, 0);

    // B: ch0, ch1, ch3 together from rr_ptr=0, served two cycles apart.
    do_reset(toggle_in);
    pulse_ready = 1'b1;
    toggle_in = toggle_in ^ 4'b1011;
    tick(3);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      check("b_valid_seq", pulse_valid, (k % 2 == 0) ? 1'b1 : 1'b0);
      if (k % 2 == 0) check("b_ch_seq", pulse_ch, b_ch[k/2]);
    end

    // C: five ch1 toggles with no consumer; saturate at 3, flag overflow.
    do_reset(toggle_in);
    for (int k = 0; k < 5; k++) begin
      toggle_in[1] = ~toggle_in[1];
      tick(4);
    end
    check("c_offer_valid", pulse_valid, 1'b1);
    check("c_offer_ch", pulse_ch, 2'd1);
    check("c_ovf_set", ovf_flag, OVF1_EXP);
    pulse_ready = 1'b1;
    cnt = 0;
    repeat (12) begin
      if (pulse_valid) begin
        cnt++;
        check("c_drain_ch", pulse_ch, 2'd1);
      end
      tick(1);
    end
    check("c_drain_count", cnt, 3);
    check("c_ovf_sticky", ovf_flag, OVF1_EXP);
    ovf_clr = 4'b0010;
    tick(1);
    ovf_clr = '0;
    check("c_ovf_clr", ovf_flag, 4'b0000);

    // D: all toggles high across reset release produce nothing.
    do_reset(4'b1111);
    pulse_ready = 1'b1;
    cnt = 0;
    repeat (50) begin tick(1); if (pulse_valid) cnt++; end
    check("d_no_pulse", cnt, 0);

    // E: busy ch0 cannot starve a single ch3 toggle.
    do_reset(toggle_in);
    pulse_ready = 1'b1;
    hs = 0; hs_at = 99; got3 = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if ((cyc % 3 == 0) && (cyc < 30)) toggle_in[0] = ~toggle_in[0];
      if (cyc == 3) toggle_in[3] = ~toggle_in[3];
      tick(1);
      if (pulse_valid && (cyc >= 3)) begin
        hs++;
        if ((pulse_ch == 2'd3) && !got3) begin
          got3  = 1'b1;
          hs_at = hs;
        end
      end
    end
    check("e_ch3_granted", got3, 1'b1);
    check("e_ch3_within_2", (hs_at <= 2), 1'b1);

    // F: reset during OFFER drops valid at once, no stale pulses afterwards.
    do_reset(toggle_in);
    toggle_in[2] = ~toggle_in[2];
    found = 1'b0;
    for (int k = 0; (k < 10) && !found; k++) begin
      tick(1);
      found = pulse_valid;
    end
    check("f_offer", found, 1'b1);
    #1 resetn = 1'b0;
    #1;
    check("f_async_valid", pulse_valid, 1'b0);
    check("f_async_ch", pulse_ch, 2'd0);
    tick(2);
    resetn = 1'b1;
    pulse_ready = 1'b1;
    cnt = 0;
    repeat (30) begin tick(1); if (pulse_valid) cnt++; end
    check("f_no_stale", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
